// File: rtl/mmm_nlp_redc_256b.sv
// Radix-2 bit-serial Montgomery reduction: o_res = T * 2^-IDW mod M for odd M.
// One conditional-add-and-halve step per cycle, then one final conditional subtract.
module mmm_nlp_redc_256b #(
  parameter int unsigned IDW = 256,
  parameter int unsigned PW  = 2 * IDW
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [PW-1:0]  i_t,
  input  logic [IDW-1:0] i_m,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [IDW-1:0] o_res,
  output logic           o_err
);

  localparam int unsigned CW = $clog2(IDW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, SUB, DONE} state_t;

  state_t         state;
  logic [PW:0]    acc;
  logic [IDW-1:0] m;
  logic [CW-1:0]  cnt;
  logic [PW+1:0]  sum;
  logic [IDW:0]   top;
  logic [IDW:0]   diff;

  // Sum kept one bit wider than acc so the carry survives before the halving.
  always_comb begin
    sum  = {1'b0, acc} + (acc[0] ? {{(PW + 2 - IDW){1'b0}}, m} : '0);
    top  = acc[IDW:0];
    diff = top - {1'b0, m};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      m       <= '0;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_res   <= '0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            acc     <= {1'b0, i_t};
            m       <= i_m;
            cnt     <= '0;
            o_ready <= 1'b0;
            if (!i_m[0]) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_err   <= 1'b1;
              o_res   <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= sum[PW+1:1];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(IDW - 1)) state <= SUB;
        end
        SUB: begin
          o_res   <= (top >= {1'b0, m}) ? diff[IDW-1:0] : top[IDW-1:0];
          o_err   <= 1'b0;
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_nlp_redc_256b.sv
// Scoreboard bench for mmm_nlp_redc_256b: driver pushes expected results,
// a negedge monitor pops and checks value, error flag and latency.
module tb_mmm_nlp_redc_256b;

  localparam int unsigned IDW = 256;
  localparam int unsigned PW  = 512;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic [PW-1:0]  t_in;
  logic [IDW-1:0] m_in;
  logic           out_valid;
  logic           in_ready;
  logic [IDW-1:0] res;
  logic           err;

  mmm_nlp_redc_256b #(.IDW(IDW), .PW(PW)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(in_valid),
    .o_ready(out_ready),
    .i_t    (t_in),
    .i_m    (m_in),
    .o_valid(out_valid),
    .i_ready(in_ready),
    .o_res  (res),
    .o_err  (err)
  );

  typedef struct {
    logic [IDW-1:0] res;
    logic           err;
    int unsigned    acc_cyc;
    int unsigned    lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          tests;
  int          fails;

  logic [IDW-1:0] mp;
  logic [IDW-1:0] me;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [IDW-1:0] act, input logic [IDW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Word-level Montgomery reference: k = -T * M^-1 mod 2^IDW via Newton inverse.
  function automatic logic [IDW-1:0] ref_redc(input logic [PW-1:0] t, input logic [IDW-1:0] m);
    logic [IDW-1:0] inv;
    logic [IDW-1:0] k;
    logic [PW:0]    s;
    logic [IDW:0]   x;
    inv = m;
    for (int i = 0; i < 8; i++) inv = inv * (IDW'(2) - m * inv);
    k = '0 - (t[IDW-1:0] * inv);
    s = {1'b0, t} + ({{(IDW + 1){1'b0}}, k} * {{(IDW + 1){1'b0}}, m});
    x = s[PW:IDW];
    if (x >= {1'b0, m}) x = x - {1'b0, m};
    return x[IDW-1:0];
  endfunction

  function automatic logic [IDW-1:0] rand_wide();
    logic [IDW-1:0] v;
    for (int i = 0; i < IDW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      if (out_ready) break;
      @(negedge clk);
    end
    if (!out_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: o_ready got 0 expected 1");
    end
  endtask

  task automatic send(input logic [PW-1:0] t, input logic [IDW-1:0] m,
                      input logic [IDW-1:0] eres, input logic eerr, input int unsigned lat);
    exp_t e;
    wait_ready();
    t_in     = t;
    m_in     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t_in     = {rand_wide(), rand_wide()};
    m_in     = rand_wide();
    e.res     = eres;
    e.err     = eerr;
    e.acc_cyc = cyc;
    e.lat     = lat;
    sb.push_back(e);
  endtask

  // Monitor: one check per rising edge of o_valid.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got res %h with no request outstanding", res);
        end else begin
          e = sb.pop_front();
          chk("res", res, e.res);
          chk("err", IDW'(err), IDW'(e.err));
          chk("latency", IDW'(cyc - e.acc_cyc + 1), IDW'(e.lat));
        end
      end
      prev = out_valid;
    end
  end

  initial begin
    logic [PW-1:0]  t;
    logic [IDW-1:0] a;
    logic [IDW-1:0] b;
    logic [PW-1:0]  r256;
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b1;
    t_in     = '0;
    m_in     = '0;
    mp       = '1;
    mp       = mp - IDW'(188);
    me       = '1;
    me       = me - IDW'(1);
    r256     = '0;
    r256[IDW] = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", IDW'(out_valid), '0);
    chk("reset_ready", IDW'(out_ready), IDW'(1));
    chk("reset_res", res, '0);
    chk("reset_err", IDW'(err), '0);
    rst = 1'b0;

    send(r256, mp, IDW'(1), 1'b0, 258);
    send('0, mp, '0, 1'b0, 258);
    send({{IDW{1'b0}}, mp}, mp, '0, 1'b0, 258);
    send(r256, me, '0, 1'b1, 1);
    send(PW'(3), IDW'(13), IDW'(1), 1'b0, 258);

    for (int n = 0; n < 100; n++) begin
      a = rand_wide();
      b = rand_wide();
      if (a >= mp) a = a - mp;
      if (b >= mp) b = b - mp;
      t = {{IDW{1'b0}}, a} * {{IDW{1'b0}}, b};
      send(t, mp, ref_redc(t, mp), 1'b0, 258);
    end

    // Backpressure: result must hold while i_valid pulses are ignored.
    wait_ready();
    in_ready = 1'b0;
    send(r256, mp, IDW'(1), 1'b0, 258);
    for (int i = 0; i < 400; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      t_in     = '0;
      m_in     = me;
      @(negedge clk);
      chk("hold_valid", IDW'(out_valid), IDW'(1));
      chk("hold_res", res, IDW'(1));
      chk("hold_ready", IDW'(out_ready), '0);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", IDW'(out_valid), '0);
    chk("release_ready", IDW'(out_ready), IDW'(1));

    // Reset mid-RUN aborts with no result.
    send(r256, mp, IDW'(1), 1'b0, 258);
    repeat (100) @(posedge clk);
    #1;
    void'(sb.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_valid", IDW'(out_valid), '0);
    chk("abort_ready", IDW'(out_ready), IDW'(1));
    chk("abort_res", res, '0);
    send(r256, mp, IDW'(1), 1'b0, 258);

    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
    end
    repeat (300) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmm_nlp_redc_256b.md
MMM_NLP_REDC_256B -- requirements
Module: mmm_nlp_redc_256b

Interface
REQ-001 SHALL have parameter IDW, default 256, operand/modulus width in bits.
REQ-002 SHALL have parameter PW, default 2*IDW, product input width.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  product/modulus request valid.
REQ-006 SHALL have port o_ready  output  1  block is able to accept a request.
REQ-007 SHALL have port i_t  input  PW  product T, as produced by the mmm_nlp multiplier.
REQ-008 SHALL have port i_m  input  IDW  modulus M.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port o_res  output  IDW  reduced result T*2^-IDW mod M.
REQ-012 SHALL have port o_err  output  1  even-modulus error flag, qualified by o_valid.

Function
REQ-013 SHALL compute o_res = T*2^-IDW mod M, fully reduced to 0..M-1, for odd M and T < M*2^IDW.
REQ-014 SHALL implement radix-2 bit-serial Montgomery reduction: one iteration per cycle, acc = (acc + acc[0]*M) >> 1.
REQ-015 SHALL hold the accumulator at PW+1 bits so that no carry is lost.
REQ-016 SHALL use the FSM states IDLE, RUN, SUB and DONE.
REQ-017 IDLE SHALL drive o_ready=1; when i_valid=1, the block SHALL capture i_t and i_m, clear the iteration counter, and go to RUN.
REQ-018 IDLE SHALL instead go directly to DONE with o_err=1 and o_res=0, skipping RUN, if the captured i_m[0]=0.
REQ-019 RUN SHALL last exactly IDW cycles, counted by a log2(IDW)+1-bit counter, and then go to SUB.
REQ-020 SUB SHALL last one cycle and SHALL load o_res with acc-M if acc>=M, else acc (the low IDW bits); it then goes to DONE.
REQ-021 DONE SHALL assert o_valid=1 and hold o_res and o_err stable until i_ready=1.
REQ-022 On the cycle in DONE where i_ready=1, the block SHALL return to IDLE on the next edge.
REQ-023 Latency SHALL be IDW+2 cycles from the accept edge to the first cycle o_valid=1 (258 cycles at default parameters).
REQ-024 o_ready SHALL be 0 in RUN, SUB and DONE; i_valid SHALL be ignored in those states, with no queuing.
REQ-025 No request SHALL be accepted in the same cycle as a result handshake; a new accept occurs at the earliest one cycle after DONE exits.
REQ-026 Behaviour for T >= M*2^IDW SHALL be unspecified, except that the FSM SHALL still complete and return to IDLE.
REQ-027 Captured operands SHALL be unaffected by changes on i_t/i_m after the accept edge.

Reset
REQ-028 While i_rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter and accumulator.
REQ-029 While i_rst=1 at a clock edge, the block SHALL set o_valid=0, o_err=0, o_res=0 and o_ready=1.
REQ-030 Reset asserted in any state, including mid-RUN or in DONE under backpressure, SHALL abort the operation with no result emitted.
REQ-031 After reset is released, the block SHALL accept a request on the first cycle with i_valid=1.

Verification
REQ-032 M=2^256-189, T=2^256 -> o_res=1, o_err=0, o_valid rises 258 cycles after accept.
REQ-033 M=2^256-189, T=0 -> o_res=0; M=2^256-189, T=M -> o_res=0.
REQ-034 M=2^256-189, 100 random a,b<M with T=a*b -> o_res matches the reference model a*b*2^-256 mod M.
REQ-035 i_ready held low for 10 cycles in DONE -> o_valid stays 1, o_res stays constant, o_ready stays 0, and i_valid pulses during the wait are ignored.
REQ-036 i_rst pulsed at RUN iteration 100 -> the next cycle is IDLE, o_valid=0, o_ready=1; a following request completes correctly in 258 cycles.
REQ-037 M=2^256-2 (even) -> o_valid rises 1 cycle after accept with o_err=1 and o_res=0.
